// File: rtl/slow_arith_pkg.sv
// Shared types for the iterative arithmetic blocks (divider, multiply-add, ...).
package slow_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slow_mul_add_if.sv
// Operand/result handshake bundle for slow_mul_add: start/valid/busy plus data.
interface slow_mul_add_if #(
  parameter int W = 16
);

  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           start;
  logic [2*W-1:0] product;
  logic           valid;
  logic           busy;

  modport master (
    output multiplicand, multiplier, addend, start,
    input  product, valid, busy
  );

  modport slave (
    input  multiplicand, multiplier, addend, start,
    output product, valid, busy
  );

endinterface

// File: rtl/slow_mul_add_counter.sv
// Iteration counter modulo W; carry_o flags the final count while enabled.
module slow_mul_add_counter #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic carry_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] TERM = CW'(W - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb carry_o = en_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = carry_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/slow_mul_add.sv
// Shift-add multiply-accumulate, one multiplier bit per clock: product = a*b + c.
// Optional SLOW_MUL_ADD_EARLY_TERM_EN stops once the remaining multiplier bits are zero.
module slow_mul_add #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        rst,
  slow_mul_add_if.slave bus
);

  import slow_arith_pkg::*;

  state_t         state_q, state_d;
  logic           accept;
  logic           carry;
  logic           last_iter;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] product_q;
  logic           valid_q;

  slow_mul_add_counter #(.W(W)) u_bit_cnt (
    .clk     (clk),
    .clr_i   (rst | accept),
    .en_i    (state_q == RUN),
    .carry_o (carry)
  );

`ifdef SLOW_MUL_ADD_EARLY_TERM_EN
  // Bits still to process after this cycle's shift are mplier_q[W-1:1].
  assign last_iter = carry || ((state_q == RUN) && (mplier_q[W-1:1] == '0));
`else
  assign last_iter = carry;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= {{W{1'b0}}, bus.addend};
      mcand_q  <= {{W{1'b0}}, bus.multiplicand};
      mplier_q <= bus.multiplier;
    end else if (state_q == RUN) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        product_q <= acc_q;
      end
    end
  end

  assign bus.product = product_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q == RUN);

endmodule
